thrint_dispatch: RTL and testbench

//  Per-core scheduler for thread idle (nuke), resume and reset interrupts.

---
 rtl/thrint_dispatch.sv | 181 ++++++++++++++++++
 tb/tb_thrint_dispatch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/thrint_dispatch.sv
// Per-core scheduler for thread nuke/resume/reset interrupts: one pending request per thread,
// round-robin issue with a minimum gap, and nuke-to-dead tracking with timeout reporting.
module thrint_dispatch #(
  parameter int         ISSUE_GAP  = 4,
  parameter int         MAX_WAIT   = 2000,
  parameter logic [4:0] DEAD_STATE = 5'h0
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       req_vld,
  input  logic [1:0] req_type,
  input  logic [1:0] req_tid,
  output logic       req_rdy,
  input  logic [4:0] thr_state0,
  input  logic [4:0] thr_state1,
  input  logic [4:0] thr_state2,
  input  logic [4:0] thr_state3,
  output logic       nukeint,
  output logic       resumint,
  output logic       rstint,
  output logic [3:0] rstthr,
  output logic [3:0] wait_dead,
  output logic       dead_timeout,
  output logic [1:0] timeout_tid
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  localparam logic [1:0] TYPE_NUKE   = 2'd0;
  localparam logic [1:0] TYPE_RESUME = 2'd1;
  localparam logic [1:0] TYPE_RESET  = 2'd2;
  localparam logic [1:0] TYPE_RSVD   = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_WAITD} thr_st_e;

  logic [3:0][4:0] thr_state_vec;
  logic [3:0][1:0] typ_vec;
  logic [3:0]      idle_vec;
  logic [3:0]      pend_vec;
  logic [3:0]      waitd_vec;
  logic [3:0]      acc_oh;
  logic [3:0]      grant_oh;
  logic [3:0]      timeout_new;

  logic            acc;
  logic            grant_vld;
  logic [1:0]      grant_tid;
  logic [1:0]      grant_type;

  logic [GW-1:0]   gap_reg;
  logic [1:0]      rr_ptr_reg;
  logic [3:0]      to_pend_reg;
  logic [3:0]      to_cand;
  logic [3:0]      to_rest;
  logic            to_sel_vld;
  logic [1:0]      to_sel_tid;

  assign thr_state_vec = {thr_state3, thr_state2, thr_state1, thr_state0};

  // A pending thread blocks everything; a waiting thread only refuses a second nuke.
  assign req_rdy = idle_vec[req_tid] | (waitd_vec[req_tid] & (req_type != TYPE_NUKE));

  // Reserved requests complete the handshake but never touch thread state.
  assign acc = req_vld & req_rdy & (req_type != TYPE_RSVD);

  always_comb begin
    grant_vld = 1'b0;
    grant_tid = 2'd0;
    if (gap_reg == '0) begin
      // Walk from the farthest offset down so the nearest pending thread wins.
      for (int k = 3; k >= 0; k--) begin
        if (pend_vec[rr_ptr_reg + 2'(k)]) begin
          grant_vld = 1'b1;
          grant_tid = rr_ptr_reg + 2'(k);
        end
      end
    end
  end

  assign grant_type = typ_vec[grant_tid];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_thr
      thr_st_e       st_reg;
      logic [1:0]    typ_reg;
      logic [CW-1:0] cnt_reg;
      logic          dead_seen;
      logic          cnt_hit;

      assign acc_oh[gi]   = acc && (req_tid == 2'(gi));
      assign grant_oh[gi] = grant_vld && (grant_tid == 2'(gi));
      assign dead_seen    = (thr_state_vec[gi] == DEAD_STATE);
      // The increment taking the counter to MAX_WAIT is the expiry point.
      assign cnt_hit      = (st_reg == ST_WAITD) && !dead_seen && (cnt_reg == CW'(MAX_WAIT - 1));
      assign timeout_new[gi] = cnt_hit && !acc_oh[gi];

      assign idle_vec[gi]  = (st_reg == ST_IDLE);
      assign pend_vec[gi]  = (st_reg == ST_PEND);
      assign waitd_vec[gi] = (st_reg == ST_WAITD);
      assign typ_vec[gi]   = typ_reg;
      assign wait_dead[gi] = (st_reg == ST_WAITD);

      always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
          st_reg  <= ST_IDLE;
          typ_reg <= TYPE_NUKE;
          cnt_reg <= '0;
        end else if (acc_oh[gi]) begin
          st_reg  <= ST_PEND;
          typ_reg <= req_type;
          cnt_reg <= '0;
        end else if (grant_oh[gi]) begin
          st_reg  <= (typ_reg == TYPE_NUKE) ? ST_WAITD : ST_IDLE;
          cnt_reg <= '0;
        end else if (st_reg == ST_WAITD) begin
          if (dead_seen) begin
            st_reg <= ST_IDLE;
          end else begin
            if (cnt_hit) begin
              st_reg <= ST_IDLE;
            end
            if (cnt_reg != CW'(MAX_WAIT)) begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
        end
      end
    end
  endgenerate

  // Timeouts that collide are queued and reported lowest tid first, one per cycle.
  assign to_cand = to_pend_reg | timeout_new;

  always_comb begin
    to_sel_vld = 1'b0;
    to_sel_tid = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (to_cand[k]) begin
        to_sel_vld = 1'b1;
        to_sel_tid = 2'(k);
      end
    end
  end

  assign to_rest = to_cand & ~(to_sel_vld ? (4'b0001 << to_sel_tid) : 4'b0000);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      gap_reg      <= '0;
      rr_ptr_reg   <= 2'd0;
      nukeint      <= 1'b0;
      resumint     <= 1'b0;
      rstint       <= 1'b0;
      rstthr       <= 4'b0000;
      to_pend_reg  <= 4'b0000;
      dead_timeout <= 1'b0;
      timeout_tid  <= 2'd0;
    end else begin
      if (grant_vld) begin
        gap_reg    <= GW'(ISSUE_GAP - 1);
        rr_ptr_reg <= grant_tid + 2'd1;
      end else if (gap_reg != '0) begin
        gap_reg <= gap_reg - GW'(1);
      end

      nukeint  <= grant_vld && (grant_type == TYPE_NUKE);
      resumint <= grant_vld && (grant_type == TYPE_RESUME);
      rstint   <= grant_vld && (grant_type == TYPE_RESET);
      rstthr   <= grant_vld ? (4'b0001 << grant_tid) : 4'b0000;

      to_pend_reg  <= to_rest;
      dead_timeout <= to_sel_vld;
      if (to_sel_vld) begin
        timeout_tid <= to_sel_tid;
      end
    end
  end

endmodule

// File: tb/tb_thrint_dispatch.sv
// Randomized and directed bench for thrint_dispatch against a cycle-stamped behavioural model.
module tb_thrint_dispatch;

  localparam int         GAP  = 4;
  localparam int         MAXW = 20;
  localparam logic [4:0] DEAD = 5'h0;

  localparam int M_IDLE = 0;
  localparam int M_PEND = 1;
  localparam int M_WAIT = 2;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       req_vld = 1'b0;
  logic [1:0] req_type = 2'd0;
  logic [1:0] req_tid = 2'd0;
  logic       req_rdy;
  logic [3:0][4:0] ts = {4{5'h1f}};
  logic       nukeint, resumint, rstint, dead_timeout;
  logic [3:0] rstthr, wait_dead;
  logic [1:0] timeout_tid;

  always #5 clk = ~clk;

  thrint_dispatch #(.ISSUE_GAP(GAP), .MAX_WAIT(MAXW), .DEAD_STATE(DEAD)) dut (
    .clk(clk), .rst_l(rst_l),
    .req_vld(req_vld), .req_type(req_type), .req_tid(req_tid), .req_rdy(req_rdy),
    .thr_state0(ts[0]), .thr_state1(ts[1]), .thr_state2(ts[2]), .thr_state3(ts[3]),
    .nukeint(nukeint), .resumint(resumint), .rstint(rstint), .rstthr(rstthr),
    .wait_dead(wait_dead), .dead_timeout(dead_timeout), .timeout_tid(timeout_tid)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: thread status plus the cycle at which each wait began; grants gated by last grant cycle.
  int  m_st[4];
  int  m_typ[4];
  int  m_wstart[4];
  int  m_rr;
  int  m_cyc;
  int  m_last_grant;
  bit [3:0] m_to_pend;
  bit       e_nuke, e_res, e_rst, e_to;
  bit [3:0] e_thr;
  bit [1:0] e_tid;

  task automatic model_reset();
    for (int t = 0; t < 4; t++) begin
      m_st[t] = M_IDLE; m_typ[t] = 0; m_wstart[t] = 0;
    end
    m_rr = 0; m_last_grant = -1000; m_to_pend = 4'b0;
    e_nuke = 0; e_res = 0; e_rst = 0; e_thr = 4'b0; e_to = 0; e_tid = 2'd0;
  endtask

  function automatic bit model_rdy(input logic [1:0] id, input logic [1:0] ty);
    return (m_st[id] == M_IDLE) || (m_st[id] == M_WAIT && ty != 2'd0);
  endfunction

  task automatic model_step(input bit v, input logic [1:0] ty, input logic [1:0] id,
                            input logic [3:0][4:0] st);
    bit acc;
    int g;
    bit [3:0] cand;
    acc = v && model_rdy(id, ty) && ty != 2'd3;
    g = -1;
    if (m_cyc - m_last_grant >= GAP) begin
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && m_st[(m_rr + k) % 4] == M_PEND) g = (m_rr + k) % 4;
      end
    end
    e_nuke = 0; e_res = 0; e_rst = 0; e_thr = 4'b0;
    if (g >= 0) begin
      e_nuke = (m_typ[g] == 0);
      e_res  = (m_typ[g] == 1);
      e_rst  = (m_typ[g] == 2);
      e_thr  = 4'b0001 << g;
      m_last_grant = m_cyc;
      m_rr = (g + 1) % 4;
    end
    cand = m_to_pend;
    for (int t = 0; t < 4; t++) begin
      if (acc && int'(id) == t) begin
        m_st[t] = M_PEND; m_typ[t] = int'(ty);
      end else if (g == t) begin
        if (m_typ[t] == 0) begin
          m_st[t] = M_WAIT; m_wstart[t] = m_cyc + 1;
        end else begin
          m_st[t] = M_IDLE;
        end
      end else if (m_st[t] == M_WAIT) begin
        if (st[t] == DEAD) begin
          m_st[t] = M_IDLE;
        end else if (m_cyc + 1 - m_wstart[t] == MAXW) begin
          m_st[t] = M_IDLE; cand[t] = 1'b1;
        end
      end
    end
    e_to = 0;
    for (int t = 3; t >= 0; t--) begin
      if (cand[t]) begin e_to = 1; e_tid = 2'(t); end
    end
    if (e_to) cand[e_tid] = 1'b0;
    m_to_pend = cand;
    m_cyc++;
  endtask

  task automatic check_outputs();
    bit [3:0] exp_wd;
    for (int t = 0; t < 4; t++) exp_wd[t] = (m_st[t] == M_WAIT);
    check_eq("nukeint",      32'(nukeint),      32'(e_nuke));
    check_eq("resumint",     32'(resumint),     32'(e_res));
    check_eq("rstint",       32'(rstint),       32'(e_rst));
    check_eq("rstthr",       32'(rstthr),       32'(e_thr));
    check_eq("wait_dead",    32'(wait_dead),    32'(exp_wd));
    check_eq("dead_timeout", 32'(dead_timeout), 32'(e_to));
    check_eq("timeout_tid",  32'(timeout_tid),  32'(e_tid));
  endtask

  // One clock: check registered outputs, drive inputs, check req_rdy, advance model at posedge.
  task automatic tick(input bit v, input logic [1:0] ty, input logic [1:0] id,
                      input logic [3:0][4:0] st);
    @(negedge clk);
    check_outputs();
    req_vld = v; req_type = ty; req_tid = id; ts = st;
    #1;
    check_eq("req_rdy", 32'(req_rdy), 32'(model_rdy(id, ty)));
    @(posedge clk);
    model_step(v, ty, id, st);
  endtask

  task automatic idle(input int n, input logic [3:0][4:0] st);
    for (int i = 0; i < n; i++) tick(1'b0, 2'd0, 2'd0, st);
  endtask

  logic [3:0][4:0] s_live;
  logic [3:0][4:0] s_dead2;
  logic [3:0][4:0] s_rand;

  initial begin
    s_live  = {4{5'h1f}};
    s_dead2 = s_live;
    s_dead2[2] = DEAD;
    m_cyc = 0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst_l = 1'b1;

    // Nuke thread 2, let it sit, then report dead.
    idle(10, s_live);
    tick(1'b1, 2'd0, 2'd2, s_live);
    idle(20, s_live);
    tick(1'b0, 2'd0, 2'd0, s_dead2);
    idle(4, s_live);

    // Four back-to-back requests spaced by the issue gap.
    tick(1'b1, 2'd1, 2'd0, s_live);
    tick(1'b1, 2'd2, 2'd1, s_live);
    tick(1'b1, 2'd0, 2'd2, s_live);
    tick(1'b1, 2'd1, 2'd3, s_live);
    idle(16, s_live);
    idle(1, s_dead2);

    // Thread 1 never reaches dead: expect a timeout.
    tick(1'b1, 2'd0, 2'd1, s_live);
    idle(26, s_live);

    // Duplicate nuke / resume refused while pending or waiting; resume cancels the wait.
    tick(1'b1, 2'd2, 2'd3, s_live);
    tick(1'b1, 2'd0, 2'd0, s_live);
    tick(1'b1, 2'd1, 2'd0, s_live);
    tick(1'b1, 2'd0, 2'd0, s_live);
    idle(3, s_live);
    tick(1'b1, 2'd0, 2'd0, s_live);
    tick(1'b1, 2'd1, 2'd0, s_live);
    tick(1'b1, 2'd3, 2'd2, s_live);
    idle(30, s_live);

    // Reset while thread 3 waits for dead and thread 1 is pending.
    tick(1'b1, 2'd0, 2'd3, s_live);
    tick(1'b1, 2'd0, 2'd1, s_live);
    tick(1'b0, 2'd0, 2'd0, s_live);
    #2;
    req_vld = 1'b0; req_type = 2'd0; req_tid = 2'd0;
    rst_l = 1'b0;
    #1;
    check_eq("rst_nukeint", 32'(nukeint), 32'd0);
    check_eq("rst_rstthr", 32'(rstthr), 32'd0);
    check_eq("rst_wait_dead", 32'(wait_dead), 32'd0);
    check_eq("rst_dead_timeout", 32'(dead_timeout), 32'd0);
    check_eq("rst_req_rdy", 32'(req_rdy), 32'd1);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst_l = 1'b1;
    idle(30, s_live);

    // Random traffic with occasional dead-state reports.
    for (int i = 0; i < 1500; i++) begin
      for (int t = 0; t < 4; t++) begin
        s_rand[t] = ($urandom_range(0, 24) == 0) ? DEAD : 5'($urandom_range(1, 31));
      end
      tick($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), s_rand);
    end
    idle(30, s_live);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
